// File: rtl/reflet_periph_bridge.sv
// rtl/reflet_periph_bridge.sv - CPU data port to peripheral register bus stage
// Optional posted writes: REFLET_PERIPH_BRIDGE_POSTED_WRITE_EN
module reflet_periph_bridge #(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF00,
  parameter int                        window_size    = 256,
  parameter int                        wait_states    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [base_addr_size-1:0] cpu_addr,
  input  logic [wordsize-1:0]       cpu_wdata,
  output logic                      cpu_hit,
  output logic [wordsize-1:0]       cpu_rdata,
  output logic                      cpu_ready,
  output logic                      p_enable,
  output logic [base_addr_size-1:0] p_addr,
  output logic [wordsize-1:0]       p_wdata,
  output logic                      p_we,
  input  logic [wordsize-1:0]       p_rdata
);

  localparam int w  = (wait_states < 1) ? 1 : wait_states;
  localparam int cw = (w > 1) ? $clog2(w) : 1;

`ifdef REFLET_PERIPH_BRIDGE_POSTED_WRITE_EN
  localparam bit posted = 1'b1;
`else
  localparam bit posted = 1'b0;
`endif

  // Window bounds widened so that base_addr + window_size may reach 2**base_addr_size.
  localparam logic [32:0] win_lo = 33'(base_addr);
  localparam logic [32:0] win_hi = win_lo + 33'(window_size);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [cw-1:0] count;
  logic          we;
  logic [32:0]   addr_ext;

  assign addr_ext = 33'(cpu_addr);
  assign cpu_hit  = cpu_req && (addr_ext >= win_lo) && (addr_ext < win_hi);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      we        <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      p_enable  <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      p_we      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          cpu_rdata <= '0;
          if (cpu_hit) begin
            p_addr    <= cpu_addr;
            p_wdata   <= cpu_wdata;
            we        <= cpu_we;
            p_enable  <= 1'b1;
            count     <= cw'(w - 1);
            // p_we is registered, so it is raised on the edge entering the last access cycle
            p_we      <= cpu_we && (w == 1);
            cpu_ready <= posted && cpu_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cpu_ready <= 1'b0;
          if (count == '0) begin
            p_enable  <= 1'b0;
            p_we      <= 1'b0;
            cpu_rdata <= we ? '0 : p_rdata;
            cpu_ready <= !(posted && we);
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
            p_we  <= we && (count == cw'(1));
          end
        end
        DONE: begin
          cpu_ready <= 1'b0;
          cpu_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_periph_bridge.sv
// tb/tb_reflet_periph_bridge.sv - directed bench for reflet_periph_bridge at W=1, 2 and 3
module tb_reflet_periph_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] p_rdata = '0;

  logic        hit1, ready1, en1, we1;
  logic [15:0] rdata1, addr1, wdata1;
  logic        hit2, ready2, en2, we2;
  logic [15:0] rdata2, addr2, wdata2;
  logic        hit3, ready3, en3, we3;
  logic [15:0] rdata3, addr3, wdata3;

  int errors = 0;
  int checks = 0;

`ifdef REFLET_PERIPH_BRIDGE_POSTED_WRITE_EN
  localparam bit posted = 1'b1;
`else
  localparam bit posted = 1'b0;
`endif

  always #5 clk = ~clk;

  reflet_periph_bridge #(.wait_states(1)) u1 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_hit(hit1), .cpu_rdata(rdata1), .cpu_ready(ready1),
    .p_enable(en1), .p_addr(addr1), .p_wdata(wdata1), .p_we(we1), .p_rdata(p_rdata));

  reflet_periph_bridge #(.wait_states(2)) u2 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_hit(hit2), .cpu_rdata(rdata2), .cpu_ready(ready2),
    .p_enable(en2), .p_addr(addr2), .p_wdata(wdata2), .p_we(we2), .p_rdata(p_rdata));

  reflet_periph_bridge #(.wait_states(3)) u3 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_hit(hit3), .cpu_rdata(rdata3), .cpu_ready(ready3),
    .p_enable(en3), .p_addr(addr3), .p_wdata(wdata3), .p_we(we3), .p_rdata(p_rdata));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [50:0] v1, v2, v3;
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF02; cpu_wdata = 16'hBEEF;
    for (int k = 1; k <= 2; k++) begin
      step();
      v1 = {ready1, en1, we1, rdata1, addr1, wdata1};
      v2 = {ready2, en2, we2, rdata2, addr2, wdata2};
      v3 = {ready3, en3, we3, rdata3, addr3, wdata3};
      checks++; if (v1 !== '0) begin errors++; $display("FAIL reset_w1 cycle %0d: got %h expected 0", k, v1); end
      checks++; if (v2 !== '0) begin errors++; $display("FAIL reset_w2 cycle %0d: got %h expected 0", k, v2); end
      checks++; if (v3 !== '0) begin errors++; $display("FAIL reset_w3 cycle %0d: got %h expected 0", k, v3); end
    end
    cpu_req = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_release_en: got %b expected 0", en1); end
  endtask

  task automatic test_read();
    logic [3:0]  exp_en = 4'b1001;
    logic [3:0]  exp_rdy = 4'b0010;
    logic [15:0] exp_rd;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF02; cpu_wdata = 16'h0000; p_rdata = 16'h00A5;
    #1;
    checks++; if (hit1 !== 1'b1) begin errors++; $display("FAIL read_hit: got %b expected 1", hit1); end
    // request held through DONE: re-accepted only after an IDLE cycle (k=4)
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_rd = (k == 2) ? 16'h00A5 : 16'h0000;
      checks++; if (en1 !== exp_en[k-1]) begin errors++; $display("FAIL read_en cycle %0d: got %b expected %b", k, en1, exp_en[k-1]); end
      checks++; if (ready1 !== exp_rdy[k-1]) begin errors++; $display("FAIL read_ready cycle %0d: got %b expected %b", k, ready1, exp_rdy[k-1]); end
      checks++; if (rdata1 !== exp_rd) begin errors++; $display("FAIL read_rdata cycle %0d: got %h expected %h", k, rdata1, exp_rd); end
      checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL read_we cycle %0d: got %b expected 0", k, we1); end
      if (k == 1) begin
        checks++; if (addr1 !== 16'hFF02) begin errors++; $display("FAIL read_addr: got %h expected ff02", addr1); end
      end
    end
    idle(8);
  endtask

  task automatic test_write();
    logic [4:0] exp_en = 5'b00111;
    logic [4:0] exp_we = 5'b00100;
    logic [4:0] exp_rdy;
    exp_rdy = posted ? 5'b00001 : 5'b01000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF10; cpu_wdata = 16'h1234; p_rdata = 16'hFFFF;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (en3 !== exp_en[k-1]) begin errors++; $display("FAIL write_en cycle %0d: got %b expected %b", k, en3, exp_en[k-1]); end
      checks++; if (we3 !== exp_we[k-1]) begin errors++; $display("FAIL write_we cycle %0d: got %b expected %b", k, we3, exp_we[k-1]); end
      checks++; if (ready3 !== exp_rdy[k-1]) begin errors++; $display("FAIL write_ready cycle %0d: got %b expected %b", k, ready3, exp_rdy[k-1]); end
      checks++; if (rdata3 !== 16'h0000) begin errors++; $display("FAIL write_rdata cycle %0d: got %h expected 0", k, rdata3); end
      if (exp_en[k-1]) begin
        checks++; if ({addr3, wdata3} !== 32'hFF10_1234) begin errors++; $display("FAIL write_bus cycle %0d: got %h expected ff101234", k, {addr3, wdata3}); end
      end
      // later CPU changes must not disturb the access in flight
      if (k == 1) begin cpu_req = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000; cpu_we = 1'b0; end
    end
    idle(6);
  endtask

  task automatic test_window();
    logic [15:0] outside [2] = '{16'hFEFF, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = outside[i];
      #1;
      checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL window_hit %h: got %b expected 0", outside[i], hit1); end
      for (int k = 1; k <= 3; k++) begin
        step();
        checks++; if ({en1, ready1, en3, ready3} !== 4'b0000) begin errors++; $display("FAIL window_idle %h cycle %0d: got %b expected 0000", outside[i], k, {en1, ready1, en3, ready3}); end
      end
    end
    cpu_addr = 16'hFFFF;
    #1;
    checks++; if (hit1 !== 1'b1) begin errors++; $display("FAIL window_top_hit: got %b expected 1", hit1); end
    cpu_addr = 16'hFF00;
    #1;
    checks++; if (hit1 !== 1'b1) begin errors++; $display("FAIL window_base_hit: got %b expected 1", hit1); end
    cpu_req = 1'b0;
    #1;
    checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL window_noreq_hit: got %b expected 0", hit1); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF10; cpu_wdata = 16'hABCD;
    step();
    checks++; if (en3 !== 1'b1) begin errors++; $display("FAIL abort_started: got %b expected 1", en3); end
    cpu_req = 1'b0;
    step();
    checks++; if ({en3, we3} !== 2'b10) begin errors++; $display("FAIL abort_mid: got %b expected 10", {en3, we3}); end
    reset = 1'b0;
    step();
    checks++; if ({ready3, en3, we3, rdata3, addr3, wdata3} !== '0) begin errors++; $display("FAIL abort_clear: got %h expected 0", {ready3, en3, we3, rdata3, addr3, wdata3}); end
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if ({en3, we3, ready3} !== 3'b000) begin errors++; $display("FAIL abort_after cycle %0d: got %b expected 000", k, {en3, we3, ready3}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_en = 8'b00110011;
    logic [7:0]  exp_we = 8'b00000010;
    logic [7:0]  exp_rdy;
    logic [15:0] exp_rd;
    logic [15:0] exp_addr;
    exp_rdy = posted ? 8'b01000001 : 8'b01000100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF04; cpu_wdata = 16'h0F0F; p_rdata = 16'h1111;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_rd = (k == 7) ? 16'h5A3C : 16'h0000;
      exp_addr = (k <= 2) ? 16'hFF04 : 16'hFF06;
      checks++; if (en2 !== exp_en[k-1]) begin errors++; $display("FAIL b2b_en cycle %0d: got %b expected %b", k, en2, exp_en[k-1]); end
      checks++; if (we2 !== exp_we[k-1]) begin errors++; $display("FAIL b2b_we cycle %0d: got %b expected %b", k, we2, exp_we[k-1]); end
      checks++; if (ready2 !== exp_rdy[k-1]) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", k, ready2, exp_rdy[k-1]); end
      checks++; if (rdata2 !== exp_rd) begin errors++; $display("FAIL b2b_rdata cycle %0d: got %h expected %h", k, rdata2, exp_rd); end
      if (exp_en[k-1]) begin
        checks++; if (addr2 !== exp_addr) begin errors++; $display("FAIL b2b_addr cycle %0d: got %h expected %h", k, addr2, exp_addr); end
      end
      if (k == 1) begin cpu_we = 1'b0; cpu_addr = 16'hFF06; cpu_wdata = 16'h0000; end
      if (k == 6) p_rdata = 16'h5A3C;
      if (k == 7) cpu_req = 1'b0;
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_window();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
